// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one dram_array between IF reads and DM reads/writes.
// Define DRAM_ARB_ROUND_ROBIN_EN for round-robin instead of DM-first priority.
module dram_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_wren,
  inout  wire  [DW-1:0] mem_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic          grant_dm;
  logic          pick_dm;
  logic [DW-1:0] wdata_q;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic last_dm;

  // On a tie, the port that did not win last time goes first.
  always_comb pick_dm = dm_req & (~if_req | ~last_dm);

  always_ff @(posedge clock) begin
    if (reset)
      last_dm <= 1'b0;
    else if (state == IDLE && (if_req | dm_req))
      last_dm <= pick_dm;
  end
`else
  always_comb pick_dm = dm_req;
`endif

  // The memory only drives the bus while wren is low.
  assign mem_data = mem_wren ? wdata_q : 'z;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant_dm    <= 1'b0;
      mem_address <= '0;
      mem_wren    <= 1'b0;
      wdata_q     <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            grant_dm    <= pick_dm;
            mem_address <= pick_dm ? dm_addr : if_addr;
            mem_wren    <= pick_dm & dm_we;
            if (pick_dm)
              wdata_q <= dm_wdata;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_wren) begin
            if (grant_dm)
              dm_rdata <= mem_data;
            else
              if_rdata <= mem_data;
          end
          mem_wren <= 1'b0;
          if_ack   <= ~grant_dm;
          dm_ack   <= grant_dm;
          state    <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed table, corner sequences and random traffic
// against a byte-wide little-endian memory model on the shared bus.
module tb_dram_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [7:0]  mem_address;
  logic        mem_wren;
  wire  [31:0] mem_data;
  logic        busy;

  dram_port_arbiter #(.AW(8), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_data(mem_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]  mem [256];
  logic [7:0]  shadow [256];
  logic        mem_clr;
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] mem_rd;

  always_comb begin
    a0 = mem_address;
    a1 = mem_address + 8'd1;
    a2 = mem_address + 8'd2;
    a3 = mem_address + 8'd3;
    mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  assign mem_data = mem_wren ? 'z : mem_rd;

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wren) begin
      mem[a0] <= mem_data[7:0];
      mem[a1] <= mem_data[15:8];
      mem[a2] <= mem_data[23:16];
      mem[a3] <= mem_data[31:24];
    end
  end

  int errors = 0;
  int checks = 0;
  int bus_errs = 0;
  bit mon_en = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if ($isunknown(mem_wren)) begin
        bus_errs++;
        $display("FAIL bus_wren: mem_wren=%b, required 0 or 1", mem_wren);
      end else if (!mem_wren && mem_data !== mem_rd) begin
        bus_errs++;
        $display("FAIL bus_read: mem_data=%h, required %h", mem_data, mem_rd);
      end else if (mem_wren && mem_data !== dm_wdata) begin
        bus_errs++;
        $display("FAIL bus_write: mem_data=%h, required %h", mem_data, dm_wdata);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] shrd(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {shadow[b3], shadow[b2], shadow[b1], shadow[a]};
  endfunction

  task automatic shwr(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    shadow[a]  = d[7:0];
    shadow[b1] = d[15:8];
    shadow[b2] = d[23:16];
    shadow[b3] = d[31:24];
  endtask

  // One access from one port; the bench re-enters with the arbiter in IDLE.
  task automatic xact(input bit isdm, input bit we,
                      input logic [7:0] a, input logic [31:0] wd);
    int n;
    bit got;
    if (isdm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      step();
      n++;
      if (n == 1) begin
        chk("access_addr", {24'h0, mem_address}, {24'h0, a});
        chk("access_wren", {31'h0, mem_wren}, {31'h0, isdm & we});
      end
      if (isdm ? dm_ack : if_ack) got = 1;
    end
    chk("ack_latency", n, 2);
    chk("other_ack", {31'h0, isdm ? if_ack : dm_ack}, 32'h0);
    chk("resp_wren", {31'h0, mem_wren}, 32'h0);
    dm_req = 1'b0;
    if_req = 1'b0;
    dm_we  = 1'b0;
    if (we)
      shwr(a, wd);
    else
      chk(isdm ? "dm_rdata" : "if_rdata", isdm ? dm_rdata : if_rdata, shrd(a));
    step();
    chk("back_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t tbl[9];
  bit          rd, rw;
  logic [7:0]  ra;
  logic [31:0] rwd;
  int          n, k, want;

  initial begin
    tbl[0] = '{1, 1, 8'h10, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    tbl[1] = '{0, 0, 8'h10, 32'h0,        32'hDEADBEEF, 32'h00000000};
    tbl[2] = '{1, 1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF, 32'h00000000};
    tbl[3] = '{1, 0, 8'h20, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
    tbl[4] = '{0, 0, 8'h20, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
    tbl[5] = '{1, 1, 8'h11, 32'h01234567, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[6] = '{0, 0, 8'h10, 32'h0,        32'h234567EF, 32'hCAFEF00D};
    tbl[7] = '{1, 0, 8'h14, 32'h0,        32'h234567EF, 32'h00000001};
    tbl[8] = '{1, 0, 8'h00, 32'h0,        32'h234567EF, 32'h00000000};

    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0;
    mem_clr = 1'b1;
    do_reset();
    mem_clr = 1'b0;

    chk("rst_if_ack", {31'h0, if_ack}, 32'h0);
    chk("rst_dm_ack", {31'h0, dm_ack}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_addr", {24'h0, mem_address}, 32'h0);
    chk("rst_bus", mem_data, 32'h0);
    mon_en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      xact(tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wd);
      chk("tbl_if_rdata", if_rdata, tbl[i].exp_if);
      chk("tbl_dm_rdata", dm_rdata, tbl[i].exp_dm);
      if (i == 0) begin
        chk("mem_10", {24'h0, mem[8'h10]}, 32'hEF);
        chk("mem_11", {24'h0, mem[8'h11]}, 32'hBE);
        chk("mem_12", {24'h0, mem[8'h12]}, 32'hAD);
        chk("mem_13", {24'h0, mem[8'h13]}, 32'hDE);
      end
    end

    for (int r = 0; r < 24; r++) begin
      rd  = 1'($urandom_range(0, 1));
      rw  = rd & 1'($urandom_range(0, 1));
      ra  = 8'h80 + 8'($urandom_range(0, 60));
      rwd = $urandom;
      xact(rd, rw, ra, rwd);
    end

    // Reset lands while a write is in ACCESS: write commits, no ack.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h40; dm_wdata = 32'h12345678;
    step();
    chk("rstw_wren", {31'h0, mem_wren}, 32'h1);
    reset = 1'b1;
    dm_req = 1'b0;
    step();
    chk("rstw_ack", {31'h0, dm_ack}, 32'h0);
    chk("rstw_busy", {31'h0, busy}, 32'h0);
    chk("rstw_wren0", {31'h0, mem_wren}, 32'h0);
    chk("rstw_dm_rdata", dm_rdata, 32'h0);
    chk("rstw_if_rdata", if_rdata, 32'h0);
    reset = 1'b0;
    dm_we = 1'b0;
    shwr(8'h40, 32'h12345678);
    step();
    chk("rstw_noack", {31'h0, dm_ack}, 32'h0);
    chk("rstw_idle", {31'h0, busy}, 32'h0);
    xact(1, 0, 8'h40, 32'h0);
    chk("rstw_readback", dm_rdata, 32'h12345678);

    // Both ports request together; DM wins first, then IF.
    do_reset();
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    want = 4;
`else
    want = 2;
`endif
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h10;
    n = 0;
    k = 0;
    while (k < want && n < 20) begin
      step();
      n++;
      if (dm_ack | if_ack) begin
        chk("sim_port", {31'h0, dm_ack}, {31'h0, (k % 2) == 0});
        chk("sim_cycle", n, 2 + 3 * k);
        if (dm_ack)
          chk("sim_dm_rdata", dm_rdata, shrd(8'h20));
        else
          chk("sim_if_rdata", if_rdata, shrd(8'h10));
`ifndef DRAM_ARB_ROUND_ROBIN_EN
        if (dm_ack) dm_req = 1'b0;
        else if_req = 1'b0;
`endif
        k++;
      end
    end
    chk("sim_count", k, want);
    dm_req = 1'b0;
    if_req = 1'b0;
    step();
    step();
    chk("sim_idle", {31'h0, busy}, 32'h0);

    mon_en = 0;
    chk("bus_discipline", bus_errs, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
